// File: rtl/uio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// uio_bus_arbiter
//
// Shares the 8-bit bidirectional uio pin bank between a transmit source
// (drives the pins) and a receive sink (samples the pins). Owns uio_oe and
// inserts released-bus turnaround cycles whenever the pin direction changes.
//
// Parameters:
//   BURST_MAX  - maximum beats per grant (1..15)
//   TURNAROUND - released-bus cycles on a direction change (1..3)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 design enable; low forces the bus released
//   tx_req/tx_data/tx_last, tx_ack   transmit requester handshake
//   rx_req, rx_data/rx_valid         receive requester handshake
//   gnt_tx, gnt_rx      grant indicators
//   uio_in/uio_out/uio_oe            pad side
//
// Configuration macro:
//   UIO_ARB_PARK_EN - when defined, the bus stays parked in the output
//                     direction (driving the last byte) after a TX burst.
// ---------------------------------------------------------------------------
module uio_bus_arbiter #(
  parameter int BURST_MAX  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ack,
  input  logic       rx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       gnt_tx,
  output logic       gnt_rx,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int            CW         = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BEAT_LIMIT = CW'(BURST_MAX);
  localparam logic [1:0]    TURN_LAST  = 2'(TURNAROUND - 1);
  localparam logic          DIR_OUT    = 1'b1;
  localparam logic          DIR_IN     = 1'b0;
  localparam logic          GNT_TX     = 1'b1;
  localparam logic          GNT_RX     = 1'b0;

`ifdef UIO_ARB_PARK_EN
  localparam logic RELEASE_AFTER_TX = 1'b0;
`else
  localparam logic RELEASE_AFTER_TX = 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    TX   = 2'd2,
    RX   = 2'd3
  } state_t;

  state_t        state_r,     state_s;
  logic          last_dir_r,  last_dir_s;   // 1 = bus last driven outward
  logic          last_gnt_r,  last_gnt_s;   // 1 = TX held the last grant
  logic          turn_tx_r,   turn_tx_s;    // grant target after TURN
  logic [1:0]    turn_cnt_r,  turn_cnt_s;
  logic [CW-1:0] beat_cnt_r,  beat_cnt_s;
  logic          rel_pend_r,  rel_pend_s;   // release bus at end of this IDLE
  logic          oe_r,        oe_s;
  logic [7:0]    out_r,       out_s;
  logic [7:0]    rx_data_r,   rx_data_s;
  logic          rx_valid_r,  rx_valid_s;
  logic [CW-1:0] beat_inc_s;
  logic          win_tx_s;

  assign gnt_tx   = (state_r == TX);
  assign gnt_rx   = (state_r == RX);
  assign uio_out  = out_r;
  assign uio_oe   = {8{oe_r}};
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;

  // Next-state, arbitration and datapath decisions.
  always_comb begin
    state_s    = state_r;
    last_dir_s = last_dir_r;
    last_gnt_s = last_gnt_r;
    turn_tx_s  = turn_tx_r;
    turn_cnt_s = turn_cnt_r;
    beat_cnt_s = beat_cnt_r;
    rel_pend_s = rel_pend_r;
    oe_s       = oe_r;
    out_s      = out_r;
    rx_data_s  = rx_data_r;
    rx_valid_s = 1'b0;
    tx_ack     = 1'b0;
    beat_inc_s = beat_cnt_r + CW'(1);

    // On a tie the side that did not hold the last grant wins.
    if (tx_req && rx_req) begin
      win_tx_s = ~last_gnt_r;
    end else begin
      win_tx_s = tx_req;
    end

    if (!ena) begin
      state_s    = IDLE;
      oe_s       = 1'b0;
      last_dir_s = DIR_IN;
      rel_pend_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rel_pend_r) begin
            oe_s       = 1'b0;
            last_dir_s = DIR_IN;
            rel_pend_s = 1'b0;
          end else begin
            rel_pend_s = 1'b0;
          end
          if (tx_req || rx_req) begin
            // A bus being released this cycle always needs a turnaround.
            if ((win_tx_s == last_dir_r) && !rel_pend_r) begin
              state_s    = win_tx_s ? TX : RX;
              beat_cnt_s = '0;
            end else begin
              state_s    = TURN;
              turn_tx_s  = win_tx_s;
              turn_cnt_s = 2'd0;
              oe_s       = 1'b0;
            end
          end else begin
            state_s = IDLE;
          end
        end
        TURN: begin
          if (turn_cnt_r == TURN_LAST) begin
            state_s    = turn_tx_r ? TX : RX;
            beat_cnt_s = '0;
          end else begin
            turn_cnt_s = turn_cnt_r + 2'd1;
          end
        end
        TX: begin
          tx_ack = tx_req;
          if (tx_req) begin
            out_s      = tx_data;
            oe_s       = 1'b1;
            beat_cnt_s = beat_inc_s;
          end else begin
            beat_cnt_s = beat_cnt_r;
          end
          if (!tx_req || tx_last || (beat_inc_s == BEAT_LIMIT)) begin
            state_s    = IDLE;
            last_gnt_s = GNT_TX;
            last_dir_s = DIR_OUT;
            rel_pend_s = RELEASE_AFTER_TX;
          end else begin
            state_s = TX;
          end
        end
        RX: begin
          if (rx_req) begin
            rx_data_s  = uio_in;
            rx_valid_s = 1'b1;
            beat_cnt_s = beat_inc_s;
          end else begin
            beat_cnt_s = beat_cnt_r;
          end
          if (!rx_req || (beat_inc_s == BEAT_LIMIT)) begin
            state_s    = IDLE;
            last_gnt_s = GNT_RX;
            last_dir_s = DIR_IN;
          end else begin
            state_s = RX;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_dir_r <= DIR_IN;
      last_gnt_r <= GNT_RX;
      turn_tx_r  <= 1'b0;
      turn_cnt_r <= 2'd0;
      beat_cnt_r <= '0;
      rel_pend_r <= 1'b0;
      oe_r       <= 1'b0;
      out_r      <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_dir_r <= last_dir_s;
      last_gnt_r <= last_gnt_s;
      turn_tx_r  <= turn_tx_s;
      turn_cnt_r <= turn_cnt_s;
      beat_cnt_r <= beat_cnt_s;
      rel_pend_r <= rel_pend_s;
      oe_r       <= oe_s;
      out_r      <= out_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for uio_bus_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_uio_bus_arbiter;

  localparam int BM = 4;
  localparam int TA = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ack;
  logic       rx_req = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       gnt_tx;
  logic       gnt_rx;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  uio_bus_arbiter #(.BURST_MAX(BM), .TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .tx_req(tx_req), .tx_data(tx_data), .tx_last(tx_last), .tx_ack(tx_ack),
    .rx_req(rx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .gnt_tx(gnt_tx), .gnt_rx(gnt_rx),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: 0 nobody, 1 transmitter, 2 receiver; turn_left > 0 means the
  // owner is still waiting out the turnaround with the bus released.
  bit   park;
  int   owner, turn_left, beats;
  bit   drove_out, last_was_tx, release_due;
  bit [7:0] m_out, m_rxd;
  bit   m_oe, m_rxv;

  task automatic model_reset();
    owner = 0; turn_left = 0; beats = 0;
    drove_out = 1'b0; last_was_tx = 1'b0; release_due = 1'b0;
    m_out = 8'h00; m_rxd = 8'h00; m_oe = 1'b0; m_rxv = 1'b0;
  endtask

  task automatic compare_all();
    bit e_gtx, e_grx;
    e_gtx = (owner == 1) && (turn_left == 0);
    e_grx = (owner == 2) && (turn_left == 0);
    check_eq("gnt_tx",   8'(gnt_tx),   8'(e_gtx));
    check_eq("gnt_rx",   8'(gnt_rx),   8'(e_grx));
    check_eq("tx_ack",   8'(tx_ack),   8'(ena && e_gtx && tx_req));
    check_eq("uio_out",  uio_out,      m_out);
    check_eq("uio_oe",   uio_oe,       {8{m_oe}});
    check_eq("rx_data",  rx_data,      m_rxd);
    check_eq("rx_valid", 8'(rx_valid), 8'(m_rxv));
  endtask

  task automatic model_step();
    bit nrxv, was_out, rel;
    int want;
    nrxv = 1'b0;
    if (!ena) begin
      owner = 0; turn_left = 0; m_oe = 1'b0; drove_out = 1'b0; release_due = 1'b0;
    end else if (owner != 0 && turn_left > 0) begin
      turn_left = turn_left - 1;
    end else if (owner == 0) begin
      was_out = drove_out;
      rel     = release_due;
      if (release_due) begin
        m_oe = 1'b0; drove_out = 1'b0; release_due = 1'b0;
      end
      if (tx_req || rx_req) begin
        if (tx_req && rx_req) want = last_was_tx ? 2 : 1;
        else want = tx_req ? 1 : 2;
        owner = want;
        beats = 0;
        if (rel || ((want == 1) != was_out)) begin
          turn_left = TA;
          m_oe = 1'b0;
        end
      end
    end else if (owner == 1) begin
      if (tx_req) begin
        m_out = tx_data; m_oe = 1'b1; beats++;
      end
      if (!tx_req || tx_last || beats == BM) begin
        owner = 0; last_was_tx = 1'b1; drove_out = 1'b1; release_due = !park;
      end
    end else begin
      if (rx_req) begin
        m_rxd = uio_in; nrxv = 1'b1; beats++;
      end
      if (!rx_req || beats == BM) begin
        owner = 0; last_was_tx = 1'b0; drove_out = 1'b0;
      end
    end
    m_rxv = nrxv;
  endtask

  // Snapshot of DUT outputs taken at the falling edge of the last tick.
  logic       o_gtx, o_grx, o_ack, o_rxv;
  logic [7:0] o_out, o_oe, o_rxd;

  task automatic tick();
    @(negedge clk);
    o_gtx = gnt_tx; o_grx = gnt_rx; o_ack = tx_ack; o_rxv = rx_valid;
    o_out = uio_out; o_oe = uio_oe; o_rxd = rx_data;
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tx_req = 1'b0; rx_req = 1'b0; tx_last = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int idx, turn_cnt, rxv_cnt, ng, gap, ncyc, stage;
    bit rx_granted, prev, found;
    logic [7:0] rx_val;
    logic [7:0] seen[$];
    int gseq[4];
    int gaps[4];

`ifdef UIO_ARB_PARK_EN
    park = 1'b1;
`else
    park = 1'b0;
`endif

    // Reset and idle
    model_reset();
    @(negedge clk);
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1; ena = 1'b1;
    idle(10);
    check_eq("idle_oe", uio_oe, 8'h00);
    check_eq("idle_out", uio_out, 8'h00);

    // TX burst A1.. then RX request raised as the burst ends
    tx_req = 1'b1; idx = 0; turn_cnt = 0; rxv_cnt = 0; rx_granted = 1'b0; rx_val = 8'h00;
    for (int c = 0; c < 30; c++) begin
      tx_data = 8'hA1 + 8'(idx);
      tick();
      if (o_oe == 8'hFF && (seen.size() == 0 || seen[$] != o_out)) seen.push_back(o_out);
      if (o_ack) idx++;
      if (idx == 4 && !o_gtx && !o_grx && o_oe == 8'h00 && !rx_granted) turn_cnt++;
      if (o_grx && !rx_granted) begin rx_granted = 1'b1; rx_req = 1'b0; end
      if (o_rxv) begin rxv_cnt++; rx_val = o_rxd; end
      if (idx == 4 && tx_req) begin tx_req = 1'b0; uio_in = 8'h5C; rx_req = 1'b1; end
    end
    check_eq("tx_acks", 8'(idx), 8'd4);
    check_eq("tx_seen_n", 8'(seen.size()), 8'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check_eq("tx_seq", seen[i], 8'hA1 + 8'(i));
    check_eq("rx_turn", 8'(turn_cnt), 8'(TA));
    check_eq("rx_pulses", 8'(rxv_cnt), 8'd1);
    check_eq("rx_byte", rx_val, 8'h5C);
    idle(3);

    // Tie: both requesting continuously
    tx_req = 1'b1; rx_req = 1'b1; ng = 0; gap = 0; prev = 1'b0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      tx_data = 8'($urandom_range(0, 255));
      tick();
      if (o_gtx || o_grx) begin
        if (!prev) begin gseq[ng] = o_gtx ? 1 : 2; gaps[ng] = gap; ng++; end
        prev = 1'b1; gap = 0;
      end else begin
        prev = 1'b0; gap++;
      end
    end
    tx_req = 1'b0; rx_req = 1'b0;
    check_eq("tie_grants", 8'(ng), 8'd4);
    for (int i = 0; i < ng; i++) begin
      check_eq("tie_order", 8'(gseq[i]), (i % 2 == 0) ? 8'd1 : 8'd2);
      check_eq("tie_gap", 8'(gaps[i]), 8'(TA + 1));
    end
    idle(4);

    // Early end: tx_last on beat 2
    tx_req = 1'b1; idx = 0; ncyc = 0;
    for (int c = 0; c < 15; c++) begin
      tx_last = (idx == 1);
      tx_data = 8'hB0 + 8'(idx);
      tick();
      if (o_ack) idx++;
      if (o_gtx) ncyc++;
      if (idx == 2) begin tx_req = 1'b0; tx_last = 1'b0; end
    end
    check_eq("last_acks", 8'(idx), 8'd2);
    check_eq("last_gnt_cyc", 8'(ncyc), 8'd2);
    idle(4);

    // ena dropped during beat 2
    tx_req = 1'b1; idx = 0; stage = 0;
    for (int c = 0; c < 15; c++) begin
      tx_data = 8'hC0 + 8'(idx);
      tick();
      if (o_ack) idx++;
      if (stage == 2) begin
        check_eq("abort_gnt", 8'(o_gtx), 8'd0);
        check_eq("abort_oe", o_oe, 8'h00);
        stage = 3;
      end else if (stage == 1) begin
        ena = 1'b1; tx_req = 1'b0; stage = 2;
      end else if (stage == 0 && idx == 1) begin
        ena = 1'b0; stage = 1;
      end
    end
    check_eq("abort_stage", 8'(stage), 8'd3);
    check_eq("abort_acks", 8'(idx), 8'd1);
    idle(4);

    // Asynchronous reset mid-burst
    tx_req = 1'b1; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tx_data = 8'($urandom_range(0, 255));
      tick();
      if (o_oe == 8'hFF && o_gtx) found = 1'b1;
    end
    check_eq("rst_burst_seen", 8'(found), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_oe", uio_oe, 8'h00);
    check_eq("rst_async_gnt", 8'(gnt_tx), 8'd0);
    model_reset();
    tx_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      ena     = ($urandom_range(0, 31) != 0);
      tx_req  = ($urandom_range(0, 3) != 0);
      rx_req  = ($urandom_range(0, 3) != 0);
      tx_last = ($urandom_range(0, 5) == 0);
      tx_data = 8'($urandom_range(0, 255));
      uio_in  = 8'($urandom_range(0, 255));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
